// File: rtl/uart_apb_pkg.sv
// Shared constants for the UART APB subsystem.
// Register offsets, bit positions and bus width.
package uart_apb_pkg;

    localparam int APB_DW = 32;

    localparam logic [3:0] RXDATA_OFS = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;
    localparam logic [3:0] CTRL_OFS   = 4'h8;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_RX_BUSY   = 3;
    localparam int ST_CNT_LSB   = 8;

    localparam int CT_RX_EN  = 0;
    localparam int CT_IRQ_EN = 1;
    localparam int CT_FLUSH  = 2;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous RX FIFO with occupancy count.
// Flush has priority over push and pop.
module uart_rx_fifo
    import uart_apb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;

    assign head  = mem[rptr];
    assign full  = (count == CNT_WIDTH'(FIFO_DEPTH));
    assign empty = (count == '0);

    // Storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        end
    end

endmodule

// File: rtl/uart_rx_apb_ctrl.sv
// APB3 slave for the UART receiver: RX FIFO,
// status/control registers and level interrupt.
module uart_rx_apb_ctrl
    import uart_apb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            paddr,
    input  logic [APB_DW-1:0]     pwdata,
    output logic [APB_DW-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rx_done_i,
    input  logic                  rx_busy_i,
    output logic                  rx_en_o,
    output logic                  irq_o
);

    logic [3:0]            ofs;
    logic                  access;
    logic                  is_rx;
    logic                  is_st;
    logic                  is_ct;
    logic                  is_bad;
    logic                  rd;
    logic                  wr;
    logic                  pop;
    logic                  push;
    logic                  push_req;
    logic                  flush;
    logic                  ovr_set;
    logic                  ovr_clr;
    logic                  overrun;
    logic                  rx_en;
    logic                  irq_en;
    logic [DATA_WIDTH-1:0] head;
    logic [CNT_WIDTH-1:0]  count;
    logic                  full;
    logic                  empty;
    logic [APB_DW-1:0]     status;

    assign ofs    = {paddr[3:2], 2'b00};
    assign access = psel & penable;
    assign is_rx  = (ofs == RXDATA_OFS);
    assign is_st  = (ofs == STATUS_OFS);
    assign is_ct  = (ofs == CTRL_OFS);
    assign is_bad = ~(is_rx | is_st | is_ct);
    assign rd     = access & ~pwrite;
    assign wr     = access & pwrite;

    // An empty read is an error and leaves the pointers alone
    assign pop      = rd & is_rx & ~empty;
    assign flush    = wr & is_ct & pwdata[CT_FLUSH];
    assign push_req = rx_done_i & rx_en & ~flush;
    assign push     = push_req & (~full | pop);
    assign ovr_set  = push_req & full & ~pop;
    assign ovr_clr  = wr & is_st & pwdata[ST_OVERRUN];

    assign pready  = 1'b1;
    assign rx_en_o = rx_en;
    assign pslverr = access & (is_bad | (is_rx & (pwrite | empty)));

    uart_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (rx_data_i),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Assemble the STATUS word from live state
    always_comb begin
        status = '0;
        status[ST_NOT_EMPTY] = ~empty;
        status[ST_FULL]      = full;
        status[ST_OVERRUN]   = overrun;
        status[ST_RX_BUSY]   = rx_busy_i;
        status[ST_CNT_LSB +: CNT_WIDTH] = count;
    end

    // Read mux, only driven during a read access
    always_comb begin
        prdata = '0;
        if (rd) begin
            unique case (1'b1)
                is_rx:  prdata = empty ? '0 : APB_DW'(head);
                is_st:  prdata = status;
                is_ct:  prdata = APB_DW'({irq_en, rx_en});
                is_bad: prdata = '0;
                default: prdata = '0;
            endcase
        end
    end

    // Control bits; flush is a pulse and never stored
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_en  <= 1'b0;
            irq_en <= 1'b0;
        end else if (wr && is_ct) begin
            rx_en  <= pwdata[CT_RX_EN];
            irq_en <= pwdata[CT_IRQ_EN];
        end
    end

    // Sticky overrun: flush beats set, set beats clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun <= 1'b0;
        end else if (flush) begin
            overrun <= 1'b0;
        end else if (ovr_set) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    // Interrupt follows registered state one cycle later
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= irq_en & (~empty | overrun);
        end
    end

endmodule

// File: tb/tb_uart_rx_apb_ctrl.sv
// Scoreboard testbench for uart_rx_apb_ctrl.
// APB accesses queue expectations; a monitor checks them.
module tb_uart_rx_apb_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [3:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [7:0]  rx_data = '0;
    logic        rx_done = 1'b0;
    logic        rx_busy = 1'b0;
    logic        rx_en_o;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic [31:0] data;
        logic        err;
        string       name;
    } exp_t;

    exp_t q[$];

    uart_rx_apb_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .rx_data_i (rx_data),
        .rx_done_i (rx_done),
        .rx_busy_i (rx_busy),
        .rx_en_o   (rx_en_o),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    // Monitor: every access phase pops one expectation
    always @(negedge clk) begin
        if (psel && penable) begin
            exp_t e;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_access got %h", prdata);
            end else begin
                e = q.pop_front();
                if (pslverr !== e.err || pready !== 1'b1 ||
                    (e.rd && prdata !== e.data)) begin
                    errors++;
                    $display("FAIL %s got data=%h err=%b want data=%h err=%b",
                             e.name, prdata, pslverr, e.data, e.err);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apb(input logic w, input logic [3:0] a,
                       input logic [31:0] wd, input logic [31:0] ed,
                       input logic ee, input string nm,
                       input logic ps = 1'b0, input logic [7:0] pd = 8'h0);
        exp_t e;
        e.rd = ~w; e.data = ed; e.err = ee; e.name = nm;
        q.push_back(e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        if (ps) begin
            rx_done = 1'b1; rx_data = pd;
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rx_done = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] ed,
                      input logic ee, input string nm);
        apb(1'b0, a, 32'h0, ed, ee, nm);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] wd,
                      input logic ee, input string nm);
        apb(1'b1, a, wd, 32'h0, ee, nm);
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        @(posedge clk); #1;
        rx_done = 1'b1; rx_data = d;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        @(negedge clk);
        chk("rst_irq", {31'b0, irq_o}, 32'h0);
        chk("rst_rx_en", {31'b0, rx_en_o}, 32'h0);
        chk("idle_prdata", prdata, 32'h0);
        rd(4'h4, 32'h0, 1'b0, "rst_status");
        rd(4'hC, 32'h0, 1'b1, "bad_ofs");

        wr(4'h8, 32'h3, 1'b0, "ctrl_wr");
        @(negedge clk);
        chk("rx_en_on", {31'b0, rx_en_o}, 32'h1);
        rx_pulse(8'hA5);
        @(negedge clk);
        chk("irq_not_yet", {31'b0, irq_o}, 32'h0);
        @(negedge clk);
        chk("irq_rise", {31'b0, irq_o}, 32'h1);
        rx_pulse(8'h3C);
        rd(4'h4, 32'h201, 1'b0, "status_2");
        rx_busy = 1'b1;
        rd(4'h4, 32'h209, 1'b0, "status_busy");
        rx_busy = 1'b0;
        rd(4'h0, 32'hA5, 1'b0, "rd_a5");
        rd(4'h0, 32'h3C, 1'b0, "rd_3c");
        repeat (2) @(negedge clk);
        chk("irq_drop", {31'b0, irq_o}, 32'h0);

        for (int i = 0; i < 8; i++) rx_pulse(8'(i));
        rx_pulse(8'hFF);
        rd(4'h4, 32'h807, 1'b0, "status_ovr");
        for (int i = 0; i < 8; i++) rd(4'h0, 32'(i), 1'b0, "drain_ovr");
        rd(4'h4, 32'h004, 1'b0, "status_sticky");
        wr(4'h4, 32'h4, 1'b0, "w1c_ovr");
        rd(4'h4, 32'h0, 1'b0, "status_cleared");

        for (int i = 0; i < 8; i++) rx_pulse(8'(8'h10 + i));
        apb(1'b0, 4'h0, 32'h0, 32'h10, 1'b0, "full_pushpop", 1'b1, 8'h55);
        rd(4'h4, 32'h803, 1'b0, "status_pushpop");
        for (int i = 1; i < 8; i++) rd(4'h0, 32'(8'h10 + i), 1'b0, "drain_pp");
        rd(4'h0, 32'h55, 1'b0, "drain_55");
        rd(4'h4, 32'h0, 1'b0, "status_empty");

        rd(4'h0, 32'h0, 1'b1, "empty_rd");
        rd(4'h4, 32'h0, 1'b0, "status_empty2");
        apb(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, "empty_pushpop", 1'b1, 8'h11);
        rd(4'h4, 32'h101, 1'b0, "status_one");
        rd(4'h0, 32'h11, 1'b0, "rd_11");

        rx_pulse(8'h01);
        rx_pulse(8'h02);
        rx_pulse(8'h03);
        rd(4'h4, 32'h301, 1'b0, "status_3");
        apb(1'b1, 4'h8, 32'h7, 32'h0, 1'b0, "flush", 1'b1, 8'h99);
        rd(4'h4, 32'h0, 1'b0, "status_flushed");
        rd(4'h8, 32'h3, 1'b0, "ctrl_rd");
        wr(4'h0, 32'h77, 1'b1, "rxdata_wr");
        rd(4'h4, 32'h0, 1'b0, "status_after_bad_wr");

        rx_pulse(8'h21);
        rx_pulse(8'h22);
        repeat (2) @(negedge clk);
        chk("irq_burst", {31'b0, irq_o}, 32'h1);
        #3 rstn = 1'b0;
        #1;
        chk("arst_irq", {31'b0, irq_o}, 32'h0);
        chk("arst_rx_en", {31'b0, rx_en_o}, 32'h0);
        chk("arst_pslverr", {31'b0, pslverr}, 32'h0);
        @(posedge clk); #1 rstn = 1'b1;
        rd(4'h4, 32'h0, 1'b0, "arst_status");
        rd(4'h8, 32'h0, 1'b0, "arst_ctrl");

        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_left %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
